// File: rtl/csi2_pkg.sv
// ---------------------------------------------------------------------------
// csi2_pkg
// Shared types and constants for the CSI-2 receive packet path:
//   csi2_header_t    - parsed packet header (vc, dt, wc, ecc)
//   csi2_state_t     - packet controller state encoding
//   CSI2_*           - data-type and CRC constants
//   csi2_crc16_byte  - one byte step of reflected CRC-16-CCITT
// ---------------------------------------------------------------------------
package csi2_pkg;

    typedef struct packed {
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] wc;
        logic [7:0]  ecc;
    } csi2_header_t;

    localparam logic [5:0]  CSI2_SHORT_DT_MAX   = 6'h0F;
    localparam logic [5:0]  CSI2_DT_FRAME_START = 6'h00;
    localparam logic [5:0]  CSI2_DT_FRAME_END   = 6'h01;
    localparam logic [5:0]  CSI2_DT_RAW8        = 6'h2A;

    localparam logic [15:0] CSI2_CRC_POLY = 16'h8408;
    localparam logic [15:0] CSI2_CRC_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_RESYNC   = 3'd0,
        ST_IDLE     = 3'd1,
        ST_HEADER   = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_CHECKSUM = 3'd4
    } csi2_state_t;

    // Reflected CRC step: bits enter LSB first, register shifts right.
    function automatic logic [15:0] csi2_crc16_byte(input logic [15:0] crc,
                                                    input logic [7:0]  data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CSI2_CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/csi2_crc16.sv
// ---------------------------------------------------------------------------
// csi2_crc16
// Byte-wide reflected CRC-16-CCITT accumulator for CSI-2 payload checking.
// Only elaborated when CSI2_RX_CRC_CHECK_EN is defined.
//   clock   in   controller clock
//   reset_n in   asynchronous active-low reset (crc -> init)
//   clear   in   synchronous reload of the init value
//   enable  in   fold data into the running CRC this cycle
//   data    in   payload byte
//   crc     out  running CRC value
// ---------------------------------------------------------------------------
`ifdef CSI2_RX_CRC_CHECK_EN
module csi2_crc16
    import csi2_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    // Running CRC register; clear has priority over enable.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            crc <= CSI2_CRC_INIT;
        end else if (clear) begin
            crc <= CSI2_CRC_INIT;
        end else if (enable) begin
            crc <= csi2_crc16_byte(crc, data);
        end
    end

endmodule
`endif

// File: rtl/csi2_rx_packet_controller.sv
// ---------------------------------------------------------------------------
// csi2_rx_packet_controller
// Parses one CSI-2 packet per HS burst from a single-lane D-PHY byte stream
// and resets the byte receiver after every packet or stall so it re-hunts
// for the sync byte in the next burst.
// Optional: define CSI2_RX_CRC_CHECK_EN to check the payload CRC-16;
// otherwise checksum bytes are consumed and crc_error stays 0.
//
// Ports:
//   clock            in   controller clock
//   reset_n          in   asynchronous active-low reset
//   byte_data[7:0]   in   byte from D-PHY receiver
//   byte_valid       in   byte_data valid
//   phy_reset        out  synchronous reset to the D-PHY receiver
//   busy             out  packet in progress (header/payload/checksum)
//   header_valid     out  pulse, header fields updated
//   virtual_channel  out  DI[7:6]
//   data_type        out  DI[5:0]
//   word_count       out  {WC_hi, WC_lo}
//   ecc              out  header ECC byte, unchecked
//   payload_data     out  payload byte
//   payload_valid    out  payload_data valid
//   packet_end       out  pulse, packet completed
//   error_timeout    out  pulse, packet aborted on stall
//   crc_error        out  pulse with packet_end on checksum mismatch
// ---------------------------------------------------------------------------
module csi2_rx_packet_controller
    import csi2_pkg::*;
#(
    parameter int unsigned PHY_RESET_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        phy_reset,
    output logic        busy,
    output logic        header_valid,
    output logic [1:0]  virtual_channel,
    output logic [5:0]  data_type,
    output logic [15:0] word_count,
    output logic [7:0]  ecc,
    output logic [7:0]  payload_data,
    output logic        payload_valid,
    output logic        packet_end,
    output logic        error_timeout,
    output logic        crc_error
);

    localparam int unsigned RST_CNT_W = (PHY_RESET_CYCLES > 1) ? $clog2(PHY_RESET_CYCLES) : 1;
    localparam int unsigned TO_CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CNT_W'(PHY_RESET_CYCLES - 1);
    localparam logic [TO_CNT_W-1:0]  TO_LAST  = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    csi2_state_t          state;
    logic [RST_CNT_W-1:0] rst_cnt;
    logic [TO_CNT_W-1:0]  to_cnt;
    logic [1:0]           hdr_cnt;
    logic [15:0]          pay_cnt;
    logic                 cs_cnt;
    logic [7:0]           di_q;
    logic [7:0]           wc_lo_q;
    logic [7:0]           wc_hi_q;
    csi2_header_t         hdr_c;

    // Header as it stands once the ECC byte is on byte_data.
    assign hdr_c = '{vc: di_q[7:6], dt: di_q[5:0], wc: {wc_hi_q, wc_lo_q}, ecc: byte_data};

`ifdef CSI2_RX_CRC_CHECK_EN
    logic [15:0] crc_val;
    logic [7:0]  cs_lo_q;
    logic        crc_clear;
    logic        crc_en;

    // CRC restarts while waiting for a packet and folds in accepted payload.
    assign crc_clear = (state == ST_IDLE);
    assign crc_en    = (state == ST_PAYLOAD) && byte_valid;

    csi2_crc16 u_crc16 (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (crc_clear),
        .enable  (crc_en),
        .data    (byte_data),
        .crc     (crc_val)
    );
`endif

    // Packet sequencer with registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_RESYNC;
            rst_cnt         <= '0;
            to_cnt          <= '0;
            hdr_cnt         <= '0;
            pay_cnt         <= '0;
            cs_cnt          <= 1'b0;
            di_q            <= '0;
            wc_lo_q         <= '0;
            wc_hi_q         <= '0;
            phy_reset       <= 1'b1;
            busy            <= 1'b0;
            header_valid    <= 1'b0;
            virtual_channel <= '0;
            data_type       <= '0;
            word_count      <= '0;
            ecc             <= '0;
            payload_data    <= '0;
            payload_valid   <= 1'b0;
            packet_end      <= 1'b0;
            error_timeout   <= 1'b0;
            crc_error       <= 1'b0;
`ifdef CSI2_RX_CRC_CHECK_EN
            cs_lo_q         <= '0;
`endif
        end else begin
            header_valid  <= 1'b0;
            payload_valid <= 1'b0;
            packet_end    <= 1'b0;
            error_timeout <= 1'b0;
            crc_error     <= 1'b0;

            case (state)
                ST_RESYNC: begin
                    to_cnt <= '0;
                    if (rst_cnt == RST_LAST) begin
                        rst_cnt   <= '0;
                        phy_reset <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        rst_cnt <= rst_cnt + RST_CNT_W'(1);
                    end
                end

                ST_IDLE: begin
                    to_cnt <= '0;
                    if (byte_valid) begin
                        di_q    <= byte_data;
                        hdr_cnt <= 2'd1;
                        busy    <= 1'b1;
                        state   <= ST_HEADER;
                    end
                end

                default: begin
                    if (!byte_valid) begin
                        // Stall: abort once TIMEOUT_CYCLES idle cycles have elapsed.
                        if (to_cnt == TO_LAST) begin
                            to_cnt        <= '0;
                            error_timeout <= 1'b1;
                            busy          <= 1'b0;
                            phy_reset     <= 1'b1;
                            rst_cnt       <= '0;
                            state         <= ST_RESYNC;
                        end else begin
                            to_cnt <= to_cnt + TO_CNT_W'(1);
                        end
                    end else begin
                        to_cnt <= '0;
                        case (state)
                            ST_HEADER: begin
                                hdr_cnt <= hdr_cnt + 2'd1;
                                if (hdr_cnt == 2'd1) begin
                                    wc_lo_q <= byte_data;
                                end else if (hdr_cnt == 2'd2) begin
                                    wc_hi_q <= byte_data;
                                end else begin
                                    virtual_channel <= hdr_c.vc;
                                    data_type       <= hdr_c.dt;
                                    word_count      <= hdr_c.wc;
                                    ecc             <= hdr_c.ecc;
                                    header_valid    <= 1'b1;
                                    if (hdr_c.dt <= CSI2_SHORT_DT_MAX) begin
                                        packet_end <= 1'b1;
                                        busy       <= 1'b0;
                                        phy_reset  <= 1'b1;
                                        rst_cnt    <= '0;
                                        state      <= ST_RESYNC;
                                    end else if (hdr_c.wc != 16'd0) begin
                                        pay_cnt <= hdr_c.wc;
                                        state   <= ST_PAYLOAD;
                                    end else begin
                                        cs_cnt <= 1'b0;
                                        state  <= ST_CHECKSUM;
                                    end
                                end
                            end

                            ST_PAYLOAD: begin
                                payload_data  <= byte_data;
                                payload_valid <= 1'b1;
                                pay_cnt       <= pay_cnt - 16'd1;
                                if (pay_cnt == 16'd1) begin
                                    cs_cnt <= 1'b0;
                                    state  <= ST_CHECKSUM;
                                end
                            end

                            ST_CHECKSUM: begin
                                if (!cs_cnt) begin
                                    cs_cnt <= 1'b1;
`ifdef CSI2_RX_CRC_CHECK_EN
                                    cs_lo_q <= byte_data;
`endif
                                end else begin
                                    packet_end <= 1'b1;
`ifdef CSI2_RX_CRC_CHECK_EN
                                    crc_error  <= ({byte_data, cs_lo_q} != crc_val);
`endif
                                    busy       <= 1'b0;
                                    phy_reset  <= 1'b1;
                                    rst_cnt    <= '0;
                                    state      <= ST_RESYNC;
                                end
                            end

                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csi2_rx_packet_controller.sv
// ---------------------------------------------------------------------------
// tb_csi2_rx_packet_controller
// Self-checking bench: directed packets plus randomized packets, checked
// against expectations built from the packet byte layout and a CRC model.
// ---------------------------------------------------------------------------
module tb_csi2_rx_packet_controller;

    localparam int unsigned PHY_RESET_CYCLES = 4;
    localparam int unsigned TIMEOUT_CYCLES   = 1024;

    logic        clock;
    logic        reset_n;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        phy_reset;
    logic        busy;
    logic        header_valid;
    logic [1:0]  virtual_channel;
    logic [5:0]  data_type;
    logic [15:0] word_count;
    logic [7:0]  ecc;
    logic [7:0]  payload_data;
    logic        payload_valid;
    logic        packet_end;
    logic        error_timeout;
    logic        crc_error;

    csi2_rx_packet_controller #(
        .PHY_RESET_CYCLES (PHY_RESET_CYCLES),
        .TIMEOUT_CYCLES   (TIMEOUT_CYCLES)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .byte_data       (byte_data),
        .byte_valid      (byte_valid),
        .phy_reset       (phy_reset),
        .busy            (busy),
        .header_valid    (header_valid),
        .virtual_channel (virtual_channel),
        .data_type       (data_type),
        .word_count      (word_count),
        .ecc             (ecc),
        .payload_data    (payload_data),
        .payload_valid   (payload_valid),
        .packet_end      (packet_end),
        .error_timeout   (error_timeout),
        .crc_error       (crc_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    // Observed event log, sampled shortly after each rising edge.
    logic [7:0] obs_pay[$];
    int hv_seen   = 0;
    int pe_seen   = 0;
    int et_seen   = 0;
    int crc_seen  = 0;
    int bad_combo = 0;

    always @(posedge clock) begin
        #2;
        if (payload_valid) obs_pay.push_back(payload_data);
        if (header_valid)  hv_seen++;
        if (packet_end)    pe_seen++;
        if (error_timeout) et_seen++;
        if (crc_error)     crc_seen++;
        if (error_timeout && (packet_end || header_valid)) bad_combo++;
        if (header_valid && (packet_end != (data_type <= 6'h0F))) bad_combo++;
        if (crc_error && !packet_end) bad_combo++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference CRC: CRC-16-CCITT, reflected, init FFFF, no final XOR.
    function automatic logic [15:0] crc_ref(input logic [7:0] b[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (b[i]) begin
            for (int k = 0; k < 8; k++) begin
                if (c[0] ^ b[i][k]) c = (c >> 1) ^ 16'h8408;
                else                c = c >> 1;
            end
        end
        return c;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            byte_valid = 1'b0;
            byte_data  = 8'h00;
        end
    endtask

    task automatic put(input logic [7:0] b);
        @(negedge clock);
        byte_valid = 1'b1;
        byte_data  = b;
    endtask

    // Called on the sample where the resync just began; phy_reset must be
    // seen high on exactly PHY_RESET_CYCLES samples, then low.
    task automatic check_resync(input string tag);
        int hi;
        hi = 0;
        for (int i = 0; i < 50 && phy_reset; i++) begin
            hi++;
            @(negedge clock);
        end
        check({tag, "_phy_hi"}, 32'(hi), PHY_RESET_CYCLES);
    endtask

    // After reset release the reset value covers the first receiver edge,
    // so phy_reset is sampled high on PHY_RESET_CYCLES-1 following samples.
    task automatic release_reset(input string tag);
        int hi;
        int others;
        hi = 0;
        others = 0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < int'(PHY_RESET_CYCLES); i++) begin
            @(negedge clock);
            if (phy_reset) hi++;
            if (busy || header_valid || payload_valid || packet_end || error_timeout || crc_error)
                others++;
        end
        check({tag, "_phy_hi"}, 32'(hi), PHY_RESET_CYCLES - 1);
        check({tag, "_phy_low"}, 32'(phy_reset), 0);
        check({tag, "_quiet"}, 32'(others), 0);
    endtask

    task automatic run_packet(input string tag, input logic [7:0] di, input logic [15:0] wc,
                              input logic [7:0] ecc_b, input logic [7:0] pay[$],
                              input logic [15:0] cs, input int max_gap, input int last_gap);
        logic       short_pkt;
        logic       exp_crc;
        logic [7:0] bytes[$];
        int pay0, hv0, pe0, et0, crc0, exp_n, mism;
        short_pkt = (di[5:0] <= 6'h0F);
        pay0 = obs_pay.size();
        hv0 = hv_seen; pe0 = pe_seen; et0 = et_seen; crc0 = crc_seen;
        bytes = {di, wc[7:0], wc[15:8], ecc_b};
        if (!short_pkt) begin
            foreach (pay[i]) bytes.push_back(pay[i]);
            bytes.push_back(cs[7:0]);
            bytes.push_back(cs[15:8]);
        end
        foreach (bytes[i]) begin
            if (last_gap > 0 && !short_pkt && pay.size() > 0 && i == 3 + pay.size())
                idle(last_gap);
            else if (max_gap > 0)
                idle($urandom_range(max_gap, 0));
            put(bytes[i]);
        end
        @(negedge clock);
        byte_valid = 1'b0;
`ifdef CSI2_RX_CRC_CHECK_EN
        exp_crc = !short_pkt && (cs != crc_ref(pay));
`else
        exp_crc = 1'b0;
`endif
        exp_n = short_pkt ? 0 : pay.size();
        check({tag, "_end"}, 32'(packet_end), 1);
        check({tag, "_hv_same"}, 32'(header_valid), 32'(short_pkt));
        check({tag, "_crc"}, 32'(crc_error), 32'(exp_crc));
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_hdr"}, {virtual_channel, data_type, word_count, ecc}, {di, wc, ecc_b});
        check({tag, "_npay"}, 32'(obs_pay.size() - pay0), 32'(exp_n));
        mism = 0;
        for (int k = 0; k < exp_n; k++) begin
            if (pay0 + k >= obs_pay.size()) mism++;
            else if (obs_pay[pay0 + k] !== pay[k]) mism++;
        end
        check({tag, "_pay_mism"}, 32'(mism), 0);
        check({tag, "_counts"}, {8'(hv_seen - hv0), 8'(pe_seen - pe0), 8'(et_seen - et0), 8'(crc_seen - crc0)},
              {8'd1, 8'd1, 8'd0, 8'(exp_crc)});
        check_resync(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  q[$];
        logic [15:0] cs;
        int early, pay0, pe0, et0;

        reset_n    = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_phy", 32'(phy_reset), 1);
        check("rst_outs", {busy, header_valid, payload_valid, packet_end, error_timeout, crc_error,
                           virtual_channel, data_type, 8'h00},
              32'd0);
        check("rst_fields", {word_count, ecc, payload_data}, 32'd0);
        release_reset("rel");

        // Short packet 00,01,00,xx
        q = {};
        run_packet("short", 8'h00, 16'h0001, 8'h5A, q, 16'h0000, 0, 0);

        // Long RAW8 packet with correct CRC, then corrupted CS_lo
        q = {8'h11, 8'h22, 8'h33, 8'h44};
        cs = crc_ref(q);
        run_packet("long_ok", 8'h2A, 16'h0004, 8'h00, q, cs, 1, 0);
        run_packet("long_bad", 8'h2A, 16'h0004, 8'h00, q, cs ^ 16'h0001, 0, 0);

        // Zero word count, vc=1
        q = {};
        run_packet("wc0", 8'h6A, 16'h0000, 8'h33, q, crc_ref(q), 0, 0);

        // Last payload byte arrives on the final cycle before timeout: byte wins
        q = {8'hA1, 8'hB2, 8'hC3};
        run_packet("edge_gap", 8'h2A, 16'h0003, 8'h07, q, crc_ref(q), 0, TIMEOUT_CYCLES - 1);

        // Stall after 5 of 16 payload bytes
        pay0 = obs_pay.size(); pe0 = pe_seen; et0 = et_seen;
        put(8'h2A); put(8'h10); put(8'h00); put(8'h00);
        for (int i = 0; i < 5; i++) put(8'(8'h40 + i));
        early = 0;
        for (int i = 0; i < int'(TIMEOUT_CYCLES); i++) begin
            @(negedge clock);
            byte_valid = 1'b0;
            if (error_timeout || packet_end) early++;
        end
        check("to_early", 32'(early), 0);
        @(negedge clock);
        check("to_pulse", {31'd0, error_timeout}, 1);
        check("to_no_end", {31'd0, packet_end}, 0);
        check("to_busy", {31'd0, busy}, 0);
        check("to_counts", {8'(obs_pay.size() - pay0), 8'(pe_seen - pe0), 8'(et_seen - et0), 8'd0},
              {8'd5, 8'd0, 8'd1, 8'd0});
        check_resync("to");

        // Async reset after 2 payload bytes
        pe0 = pe_seen; et0 = et_seen;
        put(8'h2A); put(8'h08); put(8'h00); put(8'h00);
        put(8'h01); put(8'h02);
        @(negedge clock);
        byte_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("arst_phy", 32'(phy_reset), 1);
        check("arst_outs", {busy, header_valid, payload_valid, packet_end, error_timeout, crc_error,
                            virtual_channel, data_type, 8'h00},
              32'd0);
        check("arst_fields", {word_count, ecc, payload_data}, 32'd0);
        repeat (3) @(negedge clock);
        release_reset("arel");
        check("arst_no_evt", {16'(pe_seen - pe0), 16'(et_seen - et0)}, 32'd0);
        q = {8'h5A, 8'hA5};
        run_packet("post_rst", 8'h2A, 16'h0002, 8'h11, q, crc_ref(q), 1, 0);

        // Randomized packets
        for (int n = 0; n < 10; n++) begin
            logic [7:0]  di;
            logic [15:0] wc;
            di = 8'($urandom);
            wc = 16'($urandom_range(12, 0));
            q = {};
            for (int k = 0; k < int'(wc); k++) q.push_back(8'($urandom));
            cs = crc_ref(q);
            if ($urandom_range(3, 0) == 0) cs = cs ^ 16'h0100;
            run_packet($sformatf("rnd%0d", n), di, wc, 8'($urandom), q, cs, 2, 0);
        end

        check("illegal_combo", 32'(bad_combo), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
